// File: rtl/core_debug_host_pkg.sv
// Shared definitions for the core debug host: frame nibbles, command codes, FSM states.
package core_debug_host_pkg;

  localparam logic [3:0] HDR_NIBBLE  = 4'hA;
  localparam logic [3:0] RESP_NIBBLE = 4'h5;

  typedef enum logic [3:0] {
    CMD_RDREG = 4'h0,
    CMD_WRREG = 4'h1,
    CMD_GO    = 4'h8,
    CMD_INTGO = 4'h9,
    CMD_STEP  = 4'hA,
    CMD_STOP  = 4'hF
  } cmd_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TGT,
    ST_DAT,
    ST_ISSUE,
    ST_WAIT,
    ST_SEND
  } state_t;

  function automatic logic [7:0] status_byte(input logic timeout, input logic error);
    return {RESP_NIBBLE, 2'b00, timeout, error};
  endfunction

endpackage

// File: rtl/core_debug_host_tx_ser.sv
// Five-byte response serializer: a load strobe captures the frame, bytes leave MSB first
// under valid/busy flow control; done marks the cycle the last byte transfers.
module core_debug_host_tx_ser
  import core_debug_host_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        load,
  input  logic [39:0] frame,
  input  logic        tx_busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  logic [39:0] shift_reg;
  logic [2:0]  cnt_reg;
  logic        valid_reg;
  logic        xfer;

  assign xfer = valid_reg && !tx_busy;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= frame;
      cnt_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (xfer) begin
      // The byte on the wire is always the top of the shift register.
      shift_reg <= {shift_reg[31:0], 8'h00};
      if (cnt_reg == 3'd4) begin
        valid_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 3'd1;
      end
    end
  end

  assign tx_valid = valid_reg;
  assign tx_data  = shift_reg[39:32];
  assign busy     = valid_reg;
  assign done     = xfer && (cnt_reg == 3'd4);

endmodule

// File: rtl/core_debug_host.sv
// Host-side debug command initiator: rx byte frames -> CMD handshake -> 5-byte tx response.
// Optional WAIT timeout is compiled in with `CORE_DEBUG_HOST_TIMEOUT_EN.
module core_debug_host
  import core_debug_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRX_VALID,
  input  logic [7:0]  iRX_DATA,
  output logic        oRX_BUSY,
  output logic        oTX_VALID,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_BUSY,
  output logic        oCMD_REQ,
  input  logic        iCMD_BUSY,
  output logic [3:0]  oCMD_COMMAND,
  output logic [7:0]  oCMD_TARGET,
  output logic [31:0] oCMD_DATA,
  input  logic        iRESP_VALID,
  input  logic        iRESP_ERROR,
  input  logic [31:0] iRESP_DATA,
  output logic        oFRAME_ERROR
);

  state_t      state_reg;
  logic [1:0]  byte_cnt_reg;
  logic [3:0]  cmd_reg;
  logic [7:0]  target_reg;
  logic [31:0] data_reg;
  logic        cmd_req_reg;
  logic        frame_error_reg;

  logic        rx_accept;
  logic        rx_busy;
  logic        timeout_hit;
  logic        ser_load;
  logic        ser_busy;
  logic        ser_done;
  logic [39:0] ser_frame;

`ifdef CORE_DEBUG_HOST_TIMEOUT_EN
  logic [31:0] wait_cnt_reg;
  // Counter holds 0 on the first WAIT cycle, so TIMEOUT_CYCLES-1 marks the last one.
  assign timeout_hit = (state_reg == ST_WAIT) && (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign rx_busy   = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_SEND) || ser_busy;
  assign rx_accept = iRX_VALID && !rx_busy;

  // A real strobe always wins over a timeout landing in the same cycle.
  assign ser_load  = (state_reg == ST_WAIT) && (iRESP_VALID || timeout_hit);
  assign ser_frame = iRESP_VALID ? {status_byte(1'b0, iRESP_ERROR), iRESP_DATA}
                                 : {status_byte(1'b1, 1'b0), 32'h0};

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_reg       <= ST_HDR;
      byte_cnt_reg    <= '0;
      cmd_reg         <= '0;
      target_reg      <= '0;
      data_reg        <= '0;
      cmd_req_reg     <= 1'b0;
      frame_error_reg <= 1'b0;
`ifdef CORE_DEBUG_HOST_TIMEOUT_EN
      wait_cnt_reg    <= '0;
`endif
    end else begin
      frame_error_reg <= 1'b0;
      case (state_reg)
        ST_HDR: begin
          if (rx_accept) begin
            if (iRX_DATA[7:4] == HDR_NIBBLE) begin
              cmd_reg   <= iRX_DATA[3:0];
              state_reg <= ST_TGT;
            end else begin
              frame_error_reg <= 1'b1;
            end
          end
        end
        ST_TGT: begin
          if (rx_accept) begin
            target_reg   <= iRX_DATA;
            byte_cnt_reg <= '0;
            state_reg    <= ST_DAT;
          end
        end
        ST_DAT: begin
          if (rx_accept) begin
            data_reg <= {data_reg[23:0], iRX_DATA};
            if (byte_cnt_reg == 2'd3) begin
              cmd_req_reg <= 1'b1;
              state_reg   <= ST_ISSUE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (!iCMD_BUSY) begin
            cmd_req_reg <= 1'b0;
            state_reg   <= ST_WAIT;
`ifdef CORE_DEBUG_HOST_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (ser_load) begin
            state_reg <= ST_SEND;
          end
`ifdef CORE_DEBUG_HOST_TIMEOUT_EN
          else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
`endif
        end
        ST_SEND: begin
          if (ser_done) begin
            state_reg <= ST_HDR;
          end
        end
        default: state_reg <= ST_HDR;
      endcase
    end
  end

  core_debug_host_tx_ser u_tx_ser (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .load     (ser_load),
    .frame    (ser_frame),
    .tx_busy  (iTX_BUSY),
    .tx_valid (oTX_VALID),
    .tx_data  (oTX_DATA),
    .busy     (ser_busy),
    .done     (ser_done)
  );

  assign oRX_BUSY     = rx_busy;
  assign oCMD_REQ     = cmd_req_reg;
  assign oCMD_COMMAND = cmd_reg;
  assign oCMD_TARGET  = target_reg;
  assign oCMD_DATA    = data_reg;
  assign oFRAME_ERROR = frame_error_reg;

endmodule

// File: tb/tb_core_debug_host.sv
// Directed bench for core_debug_host; honours `CORE_DEBUG_HOST_TIMEOUT_EN for the WAIT test.
module tb_core_debug_host;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRX_VALID = 1'b0;
  logic [7:0]  iRX_DATA = '0;
  logic        oRX_BUSY;
  logic        oTX_VALID;
  logic [7:0]  oTX_DATA;
  logic        iTX_BUSY = 1'b0;
  logic        oCMD_REQ;
  logic        iCMD_BUSY = 1'b0;
  logic [3:0]  oCMD_COMMAND;
  logic [7:0]  oCMD_TARGET;
  logic [31:0] oCMD_DATA;
  logic        iRESP_VALID = 1'b0;
  logic        iRESP_ERROR = 1'b0;
  logic [31:0] iRESP_DATA = '0;
  logic        oFRAME_ERROR;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] got [5];
  int got_n;

  core_debug_host #(.TIMEOUT_CYCLES(8)) dut (
    .iCLOCK       (iCLOCK),
    .inRESET      (inRESET),
    .iRX_VALID    (iRX_VALID),
    .iRX_DATA     (iRX_DATA),
    .oRX_BUSY     (oRX_BUSY),
    .oTX_VALID    (oTX_VALID),
    .oTX_DATA     (oTX_DATA),
    .iTX_BUSY     (iTX_BUSY),
    .oCMD_REQ     (oCMD_REQ),
    .iCMD_BUSY    (iCMD_BUSY),
    .oCMD_COMMAND (oCMD_COMMAND),
    .oCMD_TARGET  (oCMD_TARGET),
    .oCMD_DATA    (oCMD_DATA),
    .iRESP_VALID  (iRESP_VALID),
    .iRESP_ERROR  (iRESP_ERROR),
    .iRESP_DATA   (iRESP_DATA),
    .oFRAME_ERROR (oFRAME_ERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (oRX_BUSY && guard < 100) begin
      tick();
      guard++;
    end
    if (oRX_BUSY) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_ready: oRX_BUSY still 1 after 100 cycles, expected 0");
    end
    iRX_VALID = 1'b1;
    iRX_DATA  = b;
    tick();
    iRX_VALID = 1'b0;
    iRX_DATA  = '0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
  endtask

  task automatic respond(input logic err, input logic [31:0] data);
    iRESP_VALID = 1'b1;
    iRESP_ERROR = err;
    iRESP_DATA  = data;
    tick();
    iRESP_VALID = 1'b0;
    iRESP_ERROR = 1'b0;
    iRESP_DATA  = '0;
  endtask

  task automatic collect_tx(input int want, input bit toggle);
    got_n = 0;
    for (int i = 0; i < 5; i++) got[i] = 8'hxx;
    for (int c = 0; c < 200 && got_n < want; c++) begin
      iTX_BUSY = toggle ? ~c[0] : 1'b0;
      if (oTX_VALID && !iTX_BUSY) begin
        got[got_n] = oTX_DATA;
        got_n++;
      end
      tick();
    end
    iTX_BUSY = 1'b0;
    $display("tx frame: %0d bytes %h %h %h %h %h", got_n, got[0], got[1], got[2], got[3], got[4]);
  endtask

  task automatic test_reset();
    inRESET = 1'b0;
    tick();
    tick();
    vectors++;
    if ({oRX_BUSY, oTX_VALID, oTX_DATA, oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA, oFRAME_ERROR} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b txv=%b txd=%h req=%b cmd=%h tgt=%h data=%h ferr=%b, expected all 0",
               oRX_BUSY, oTX_VALID, oTX_DATA, oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA, oFRAME_ERROR);
    end
    inRESET = 1'b1;
    tick();
  endtask

  task automatic test_read_reg();
    logic [39:0] exp = 40'h50_12345678;
    send_frame(48'hA0_05_00000000);
    $display("cmd issued: cmd=%h tgt=%h data=%h req=%b", oCMD_COMMAND, oCMD_TARGET, oCMD_DATA, oCMD_REQ);
    vectors++;
    if ({oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA} !== {1'b1, 4'h0, 8'h05, 32'h0}) begin
      miscompares++;
      $display("FAIL rdreg_cmd: got req=%b cmd=%h tgt=%h data=%h, expected 1 0 05 00000000",
               oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA);
    end
    vectors++;
    if (oRX_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL rdreg_rx_busy_issue: got %b expected 1", oRX_BUSY);
    end
    tick();
    vectors++;
    if (oCMD_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL rdreg_req_drop: got %b expected 0", oCMD_REQ);
    end
    respond(1'b0, 32'h12345678);
    vectors++;
    if (oTX_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL rdreg_resp_latency: oTX_VALID got %b expected 1 one cycle after strobe", oTX_VALID);
    end
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL rdreg_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
    vectors++;
    if ({oTX_VALID, oRX_BUSY} !== 2'b00) begin
      miscompares++;
      $display("FAIL rdreg_back_to_hdr: got txv=%b rxbusy=%b expected 0 0", oTX_VALID, oRX_BUSY);
    end
  endtask

  task automatic test_busy_hold();
    int req_cycles = 0;
    int accepts = 0;
    logic [39:0] exp = 40'h50_00000000;
    iCMD_BUSY = 1'b1;
    send_frame(48'hAF_00_00000000);
    vectors++;
    if (oCMD_COMMAND !== 4'hF) begin
      miscompares++;
      $display("FAIL busy_cmd: got %h expected f", oCMD_COMMAND);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        iCMD_BUSY   = 1'b0;
        // A strobe in the accept cycle must be ignored.
        iRESP_VALID = 1'b1;
        iRESP_DATA  = 32'hBAD0BAD0;
      end
      if (oCMD_REQ) req_cycles++;
      if (oCMD_REQ && !iCMD_BUSY) accepts++;
      tick();
      iRESP_VALID = 1'b0;
      iRESP_DATA  = '0;
    end
    $display("busy hold: req_cycles=%0d accepts=%0d", req_cycles, accepts);
    vectors++;
    if (req_cycles != 4) begin
      miscompares++;
      $display("FAIL busy_req_cycles: got %0d expected 4", req_cycles);
    end
    vectors++;
    if (accepts != 1) begin
      miscompares++;
      $display("FAIL busy_accepts: got %0d expected 1", accepts);
    end
    vectors++;
    if ({oTX_VALID, oRX_BUSY} !== 2'b01) begin
      miscompares++;
      $display("FAIL busy_accept_cycle_resp: got txv=%b rxbusy=%b expected 0 1 (still waiting)", oTX_VALID, oRX_BUSY);
    end
    respond(1'b0, 32'h0);
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL busy_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
  endtask

  task automatic test_resync();
    logic [39:0] exp = 40'h50_00000000;
    send_byte(8'h33);
    vectors++;
    if ({oFRAME_ERROR, oRX_BUSY} !== 2'b10) begin
      miscompares++;
      $display("FAIL resync_pulse: got ferr=%b rxbusy=%b expected 1 0", oFRAME_ERROR, oRX_BUSY);
    end
    send_byte(8'hA8);
    vectors++;
    if (oFRAME_ERROR !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_pulse_width: got %b expected 0", oFRAME_ERROR);
    end
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    vectors++;
    if ({oCMD_REQ, oCMD_COMMAND} !== {1'b1, 4'h8}) begin
      miscompares++;
      $display("FAIL resync_go_cmd: got req=%b cmd=%h expected 1 8", oCMD_REQ, oCMD_COMMAND);
    end
    tick();
    respond(1'b0, 32'h0);
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL resync_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
  endtask

  task automatic test_error_backpressure();
    logic [39:0] exp = 40'h51_DEADBEEF;
    send_frame(48'hA1_07_CAFEBABE);
    vectors++;
    if ({oCMD_COMMAND, oCMD_TARGET, oCMD_DATA} !== {4'h1, 8'h07, 32'hCAFEBABE}) begin
      miscompares++;
      $display("FAIL wrreg_cmd: got cmd=%h tgt=%h data=%h expected 1 07 cafebabe",
               oCMD_COMMAND, oCMD_TARGET, oCMD_DATA);
    end
    tick();
    respond(1'b1, 32'hDEADBEEF);
    collect_tx(5, 1'b1);
    vectors++;
    if (got_n != 5) begin
      miscompares++;
      $display("FAIL bp_count: got %0d bytes expected 5", got_n);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL bp_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
    tick();
    vectors++;
    if (oTX_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_extra: oTX_VALID got %b expected 0", oTX_VALID);
    end
  endtask

  task automatic test_wait();
`ifdef CORE_DEBUG_HOST_TIMEOUT_EN
    logic [39:0] exp_to = 40'h52_00000000;
    logic [39:0] exp_ok = 40'h50_87654321;
    send_frame(48'hAA_00_00000000);
    tick();
    for (int k = 0; k < 7; k++) tick();
    vectors++;
    if (oTX_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: oTX_VALID got %b expected 0 after 7 wait cycles", oTX_VALID);
    end
    tick();
    vectors++;
    if (oTX_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_fire: oTX_VALID got %b expected 1 after 8 wait cycles", oTX_VALID);
    end
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp_to[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL timeout_tx_byte%0d: got %h expected %h", i, got[i], exp_to[39-8*i -: 8]);
      end
    end
    send_frame(48'hAA_00_00000000);
    tick();
    for (int k = 0; k < 7; k++) tick();
    respond(1'b0, 32'h87654321);
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp_ok[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL last_cycle_tx_byte%0d: got %h expected %h", i, got[i], exp_ok[39-8*i -: 8]);
      end
    end
`else
    logic [39:0] exp = 40'h50_00000042;
    send_frame(48'hAA_00_00000000);
    tick();
    for (int k = 0; k < 40; k++) tick();
    vectors++;
    if ({oTX_VALID, oRX_BUSY} !== 2'b01) begin
      miscompares++;
      $display("FAIL wait_persist: got txv=%b rxbusy=%b expected 0 1", oTX_VALID, oRX_BUSY);
    end
    respond(1'b0, 32'h00000042);
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL wait_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    logic [39:0] exp = 40'h50_A5A5A5A5;
    send_frame(48'hA0_03_00000000);
    tick();
    respond(1'b0, 32'h11223344);
    collect_tx(2, 1'b0);
    vectors++;
    if ({got[0], got[1]} !== 16'h5011) begin
      miscompares++;
      $display("FAIL midsend_first_bytes: got %h %h expected 50 11", got[0], got[1]);
    end
    inRESET = 1'b0;
    #1;
    vectors++;
    if ({oTX_VALID, oTX_DATA, oRX_BUSY, oCMD_REQ} !== 11'b0) begin
      miscompares++;
      $display("FAIL midsend_reset: got txv=%b txd=%h rxbusy=%b req=%b expected all 0",
               oTX_VALID, oTX_DATA, oRX_BUSY, oCMD_REQ);
    end
    tick();
    inRESET = 1'b1;
    tick();
    send_frame(48'hA0_09_01020304);
    vectors++;
    if ({oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA} !== {1'b1, 4'h0, 8'h09, 32'h01020304}) begin
      miscompares++;
      $display("FAIL midsend_next_cmd: got req=%b cmd=%h tgt=%h data=%h expected 1 0 09 01020304",
               oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA);
    end
    tick();
    respond(1'b0, 32'hA5A5A5A5);
    collect_tx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[39-8*i -: 8]) begin
        miscompares++;
        $display("FAIL midsend_tx_byte%0d: got %h expected %h", i, got[i], exp[39-8*i -: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_reg();
    test_busy_hold();
    test_resync();
    test_error_backpressure();
    test_wait();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
